// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/busy/done handshake.
// One input bit is shifted per clock; bcd/ovf update only on the completing edge.
module bin2bcd_seq #(
  parameter int WIDTH  = 5,
  parameter int DIGITS = 2
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0]   scr_q, scr_d;
  logic            acc_q, acc_d;
  logic            done_q, done_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            ovf_q, ovf_d;
  logic [BW-1:0]   corr;

  // State register plus datapath flops
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      scr_q   <= '0;
      acc_q   <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  // Add-3 correction of every digit, applied before the shift
  always_comb begin
    corr = scr_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (scr_q[4*k +: 4] >= 4'd5) corr[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    scr_d   = scr_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sh_d    = bin;
          scr_d   = '0;
          acc_d   = 1'b0;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sh_d  = sh_q << 1;
        scr_d = {corr[BW-2:0], sh_q[WIDTH-1]};
        // Bit pushed out of the top digit means a discarded higher digit is nonzero
        acc_d = acc_q | corr[BW-1];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = scr_d;
          ovf_d   = acc_d;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q == SHIFT);
    done = done_q;
    bcd  = bcd_q;
    ovf  = ovf_q;
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: directed table, full 5-bit sweep, random 8-bit values,
// and handshake corner sequences, all checked against an arithmetic reference.
module tb_bin2bcd_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sel;
  logic [7:0] bin;

  logic       busy5, done5, ovf5, busy8, done8, ovf8;
  logic [7:0] bcd5, bcd8;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(5), .DIGITS(2)) dut5 (
    .CLOCK_50(clk), .RESET(rst), .start(start & ~sel), .bin(bin[4:0]),
    .busy(busy5), .done(done5), .bcd(bcd5), .ovf(ovf5));

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut8 (
    .CLOCK_50(clk), .RESET(rst), .start(start & sel), .bin(bin),
    .busy(busy8), .done(done8), .bcd(bcd8), .ovf(ovf8));

  logic       m_busy, m_done, m_ovf;
  logic [7:0] m_bcd;
  always_comb begin
    m_busy = sel ? busy8 : busy5;
    m_done = sel ? done8 : done5;
    m_ovf  = sel ? ovf8  : ovf5;
    m_bcd  = sel ? bcd8  : bcd5;
  end

  typedef struct {
    logic       w8;
    int         val;
    logic [7:0] exp_bcd;
    logic       exp_ovf;
  } vec_t;

  function automatic logic [7:0] ref_bcd(input int v);
    int m;
    m = v % 100;
    return {4'(m / 10), 4'(m % 10)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Called at the negedge after the accepting edge; returns at the negedge where done is seen
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    while (!m_done && lat < 30) begin
      if (m_busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (!m_done) begin
      fails++;
      checks++;
      $display("FAIL timeout: no done within %0d cycles", lat);
    end
  endtask

  task automatic run(input logic w8, input int v, input logic [7:0] eb, input logic eo,
                     input string name);
    int lat, bcnt, w;
    logic [7:0] held;
    w = w8 ? 8 : 5;
    @(negedge clk);
    sel = w8; bin = 8'(v); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bin = ~bin;
    wait_done(lat, bcnt);
    chk({name, " bcd"}, int'(m_bcd), int'(eb));
    chk({name, " ovf"}, int'(m_ovf), int'(eo));
    chk({name, " latency"}, lat, w);
    chk({name, " busy cycles"}, bcnt, w);
    held = m_bcd;
    @(negedge clk);
    chk({name, " done width"}, int'(m_done), 0);
    chk({name, " bcd hold"}, int'(m_bcd), int'(held));
  endtask

  vec_t vecs[$];

  initial begin
    int lat, bcnt, v;
    rst = 1'b1; start = 1'b0; sel = 1'b0; bin = '0;

    vecs.push_back('{1'b0, 0,   8'h00, 1'b0});
    vecs.push_back('{1'b0, 31,  8'h31, 1'b0});
    vecs.push_back('{1'b0, 19,  8'h19, 1'b0});
    vecs.push_back('{1'b0, 10,  8'h10, 1'b0});
    vecs.push_back('{1'b0, 9,   8'h09, 1'b0});
    vecs.push_back('{1'b1, 255, 8'h55, 1'b1});
    vecs.push_back('{1'b1, 200, 8'h00, 1'b1});
    vecs.push_back('{1'b1, 99,  8'h99, 1'b0});
    vecs.push_back('{1'b1, 100, 8'h00, 1'b1});

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset busy5", int'(busy5), 0);
    chk("reset done5", int'(done5), 0);
    chk("reset bcd5",  int'(bcd5), 0);
    chk("reset ovf5",  int'(ovf5), 0);
    chk("reset busy8", int'(busy8), 0);
    chk("reset bcd8",  int'(bcd8), 0);

    foreach (vecs[i]) run(vecs[i].w8, vecs[i].val, vecs[i].exp_bcd, vecs[i].exp_ovf, $sformatf("vec%0d", i));

    for (int i = 0; i < 32; i++) run(1'b0, i, ref_bcd(i), 1'b0, $sformatf("sweep%0d", i));

    for (int i = 0; i < 40; i++) begin
      v = int'($urandom_range(0, 255));
      run(1'b1, v, ref_bcd(v), v >= 100, $sformatf("rand8_%0d", v));
    end

    // start held through busy with a new bin; second conversion accepted from the done cycle
    @(negedge clk);
    sel = 1'b0; bin = 8'd17; start = 1'b1;
    @(negedge clk);
    bin = 8'd5;
    wait_done(lat, bcnt);
    chk("held bcd first", int'(m_bcd), 8'h17);
    chk("held latency first", lat, 5);
    @(negedge clk);
    start = 1'b0;
    chk("held busy second", int'(m_busy), 1);
    wait_done(lat, bcnt);
    chk("held bcd second", int'(m_bcd), 8'h05);
    chk("held latency second", lat, 5);

    // start pulsed exactly in the done cycle
    @(negedge clk);
    bin = 8'd12; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    chk("b2b bcd first", int'(m_bcd), 8'h12);
    chk("b2b busy in done", int'(m_busy), 0);
    bin = 8'd25; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b busy after", int'(m_busy), 1);
    wait_done(lat, bcnt);
    chk("b2b bcd second", int'(m_bcd), 8'h25);
    chk("b2b latency", lat, 5);
    chk("b2b busy cycles", bcnt, 5);

    // reset mid-conversion
    @(negedge clk);
    bin = 8'd29; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", int'(busy5), 0);
    chk("abort bcd", int'(bcd5), 0);
    chk("abort ovf", int'(ovf5), 0);
    bcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (done5 || busy5) bcnt++;
      @(negedge clk);
    end
    chk("abort no done", bcnt, 0);
    run(1'b0, 29, 8'h29, 1'b0, "after abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
